// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter and the memory wrapper.
// Holds the FSM encoding, requester IDs and the default memory latency.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between fetch and load/store for the single-port memory.
// One transaction at a time; every output is registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic              ls_err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_w,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    req_id_e           owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              last_ls_q, last_ls_d;
    logic              if_gnt_q, if_gnt_d;
    logic              ls_gnt_q, ls_gnt_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic              ls_err_q, ls_err_d;
    logic              mem_w_q, mem_w_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pick_ls;
    logic              ls_mis;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        last_ls_d   = last_ls_q;
        if_gnt_d    = if_gnt_q;
        ls_gnt_d    = ls_gnt_q;
        if_done_d   = if_done_q;
        ls_done_d   = ls_done_q;
        ls_err_d    = ls_err_q;
        mem_w_d     = mem_w_q;
        busy_d      = busy_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // On a tie the side that did not win last time gets the port.
        pick_ls     = ls_req & (~if_req | ~last_ls_q);
        ls_mis      = ls_addr[1:0] != 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                if (if_req | ls_req) begin
                    owner_d   = pick_ls ? REQ_LS : REQ_IF;
                    last_ls_d = pick_ls;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    if_gnt_d  = ~pick_ls;
                    ls_gnt_d  = pick_ls;
                    if (pick_ls && ls_mis) begin
                        state_d   = ST_DONE;
                        ls_done_d = 1'b1;
                        ls_err_d  = 1'b1;
                        we_d      = 1'b0;
                    end else begin
                        state_d    = ST_ACCESS;
                        we_d       = pick_ls & ls_we;
                        mem_w_d    = pick_ls & ls_we;
                        mem_addr_d = pick_ls ? ls_addr : if_addr;
                        if (pick_ls) begin
                            mem_wdata_d = ls_wdata;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                mem_w_d = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    if_done_d = owner_q == REQ_IF;
                    ls_done_d = owner_q == REQ_LS;
                    ls_err_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                if_gnt_d  = 1'b0;
                ls_gnt_d  = 1'b0;
                if_done_d = 1'b0;
                ls_done_d = 1'b0;
                ls_err_d  = 1'b0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_IF;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            last_ls_q   <= 1'b1;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            ls_err_q    <= 1'b0;
            mem_w_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            last_ls_q   <= last_ls_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            ls_err_q    <= ls_err_d;
            mem_w_q     <= mem_w_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign ls_err    = ls_err_q;
    assign mem_w     = mem_w_q;
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_done;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_done, ls_err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_w;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done),
        .ls_err(ls_err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | i);
    endfunction

    // Simple word memory: read data is registered once after the address.
    logic [31:0] mem [0:255];
    logic [31:0] mem_rd_q = '0;
    bit          mem_ok = 1'b0;
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_ok <= 1'b1;
        end else begin
            if (mem_w) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rd_q <= mem[mem_addr[9:2]];
        end
    end
    assign mem_rdata = mem_rd_q;

    // Transaction model: each grant owns the port for a fixed span of cycles.
    logic [31:0] ref_mem [0:255];
    bit          ref_ok = 1'b0;
    bit          chk_en = 1'b0;
    bit          act = 1'b0;
    bit          last_ls, t_ls, t_mis, t_we;
    int          k, t_len;
    logic [31:0] t_addr;
    logic        e_if_gnt, e_ls_gnt, e_if_done, e_ls_done, e_err;
    logic        e_mem_w, e_busy;
    logic [31:0] e_rdata, e_addr, e_wdata;

    always @(posedge clk) begin
        if (!ref_ok) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_ok = 1'b1;
        end
        if (reset) begin
            act = 1'b0; last_ls = 1'b1;
            e_rdata = '0; e_addr = '0; e_wdata = '0;
        end else begin
            if (act) k++;
            if (act && k == t_len + 1) begin
                act = 1'b0;
            end else if (!act && (if_req || ls_req)) begin
                t_ls  = (if_req && ls_req) ? !last_ls : ls_req;
                last_ls = t_ls;
                t_mis = t_ls && (ls_addr[1:0] != 2'b00);
                t_we  = t_ls && ls_we;
                t_addr = t_ls ? ls_addr : if_addr;
                t_len = t_mis ? 0 : LAT;
                k = 0; act = 1'b1;
                if (!t_mis) begin
                    e_addr = t_addr;
                    if (t_ls) e_wdata = ls_wdata;
                    if (t_we) ref_mem[t_addr[9:2]] = ls_wdata;
                end
            end
        end
        if (act) begin
            e_if_gnt  = !t_ls;
            e_ls_gnt  = t_ls;
            e_if_done = !t_ls && k == t_len;
            e_ls_done = t_ls && k == t_len;
            e_err     = e_ls_done && t_mis;
            e_mem_w   = k == 0 && t_we && !t_mis;
            e_busy    = 1'b1;
            if (k == t_len && !t_we && !t_mis) e_rdata = ref_mem[t_addr[9:2]];
        end else begin
            e_if_gnt = 0; e_ls_gnt = 0; e_if_done = 0; e_ls_done = 0;
            e_err = 0; e_mem_w = 0; e_busy = 0;
        end
        chk_en = 1'b1;
    end

    int   mw_cnt = 0;
    int   if_done_cnt = 0;
    int   ls_done_cnt = 0;
    int   glog [$];
    logic p_if_gnt = 1'b0;
    logic p_ls_gnt = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if_gnt});
            chk("ls_gnt", {31'b0, ls_gnt}, {31'b0, e_ls_gnt});
            chk("if_done", {31'b0, if_done}, {31'b0, e_if_done});
            chk("ls_done", {31'b0, ls_done}, {31'b0, e_ls_done});
            chk("ls_err", {31'b0, ls_err}, {31'b0, e_err});
            chk("mem_w", {31'b0, mem_w}, {31'b0, e_mem_w});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("rdata", rdata, e_rdata);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            if (mem_w) mw_cnt++;
            if (if_done) if_done_cnt++;
            if (ls_done) ls_done_cnt++;
            if (if_gnt && !p_if_gnt) glog.push_back(0);
            if (ls_gnt && !p_ls_gnt) glog.push_back(1);
            p_if_gnt = if_gnt;
            p_ls_gnt = ls_gnt;
        end
    end

    int mw0, g0, d0;
    int exp_seq [4] = '{0, 1, 0, 1};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, request dropped during ACCESS.
        mw0 = mw_cnt;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk); if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t1_if_done", {31'b0, if_done}, 32'd1);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_mem_w_cycles", mw_cnt - mw0, 32'd0);

        // Store.
        mw0 = mw_cnt;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("t2_mem_w", {31'b0, mem_w}, 32'd1);
        chk("t2_mem_addr", mem_addr, 32'h20);
        chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
        ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_ls_done", {31'b0, ls_done}, 32'd1);
        chk("t2_ls_err", {31'b0, ls_err}, 32'd0);
        chk("t2_rdata_kept", rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_mem_w_cycles", mw_cnt - mw0, 32'd1);

        // Load back the stored word.
        ls_req = 1'b1; ls_addr = 32'h20;
        @(negedge clk); ls_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t2b_rdata", rdata, 32'h1234_5678);
        @(negedge clk);

        // Both requesters held from reset.
        reset = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        if_addr = 32'h40; ls_addr = 32'h30;
        @(negedge clk);
        reset = 1'b0;
        g0 = glog.size();
        repeat (16) @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_grants", glog.size() - g0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (g0 + i < glog.size())
                chk("t3_order", glog[g0 + i], exp_seq[i]);
            else
                chk("t3_order_missing", 32'd9, exp_seq[i]);
        end

        // Misaligned load.
        mw0 = mw_cnt;
        ls_req = 1'b1; ls_addr = 32'h22;
        @(negedge clk);
        chk("t4_ls_done", {31'b0, ls_done}, 32'd1);
        chk("t4_ls_err", {31'b0, ls_err}, 32'd1);
        chk("t4_mem_addr", mem_addr, 32'h30);
        ls_req = 1'b0;
        @(negedge clk);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk("t4_mem_w_cycles", mw_cnt - mw0, 32'd0);

        // Reset in the middle of a load.
        d0 = ls_done_cnt;
        ls_req = 1'b1; ls_addr = 32'h40;
        @(negedge clk);
        chk("t5_ls_gnt", {31'b0, ls_gnt}, 32'd1);
        ls_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_no_done", ls_done_cnt - d0, 32'd0);
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk); if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_if_done", {31'b0, if_done}, 32'd1);
        chk("t5_rdata", rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Fetch request left high past done gives a second fetch.
        g0 = glog.size(); d0 = if_done_cnt;
        if_req = 1'b1; if_addr = 32'h14;
        repeat (5) @(negedge clk);
        if_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_grants", glog.size() - g0, 32'd2);
        chk("t6_dones", if_done_cnt - d0, 32'd2);
        chk("t6_rdata", rdata, 32'hA500_0005);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
